eq_run_monitor: RTL and testbench

Downstream consumer of the two-cycle equality checker's 1-bit match stream. Qualifies each sample with a valid strobe and discards the checker's first samples after reset, while its delay line fills. Tracks consecutive-match run length, peak run and total mismatches. A small lock FSM declares the stream "locked" after a sustained run of matches and reports loss of lock.

---
 rtl/eq_run_monitor_if.sv | 13 +
 rtl/eq_run_monitor.sv | 145 ++++++++++++++
 tb/tb_eq_run_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/eq_run_monitor_if.sv
// eq_run_monitor_if
//   Carries the equality checker's qualified match stream.
//   eq_in    : 1 = current checker input equals the value two cycles earlier
//   eq_valid : eq_in is meaningful on this clock edge
//   master : driven by the producer (equality checker)
//   slave  : consumed by eq_run_monitor
interface eq_run_monitor_if;
  logic eq_in;
  logic eq_valid;

  modport master (output eq_in, output eq_valid);
  modport slave  (input  eq_in, input  eq_valid);
endinterface

// File: rtl/eq_run_monitor.sv
// eq_run_monitor
//   Qualifies the equality checker's match stream, discards the warm-up
//   samples, tracks current/peak match run and total misses, and runs a
//   small lock FSM (WARMUP -> SEARCH <-> LOCKED).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   eq_bus      : eq_in / eq_valid sample stream (slave modport)
//   clear       : synchronous clear to SEARCH with zeroed counters
//   run_len     : current consecutive-match count (saturating)
//   max_run     : peak run_len since reset/clear
//   miss_cnt    : valid mismatches seen in SEARCH/LOCKED (saturating)
//   locked      : FSM is in LOCKED
//   lock_lost   : one-cycle pulse on LOCKED -> SEARCH
//   state       : 0 = WARMUP, 1 = SEARCH, 2 = LOCKED
module eq_run_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WARMUP      = 2,
  parameter int unsigned LOCK_RUN    = 4,
  parameter int unsigned UNLOCK_MISS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  eq_run_monitor_if.slave    eq_bus,
  input  logic               clear,
  output logic [CNT_W-1:0]   run_len,
  output logic [CNT_W-1:0]   max_run,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic               locked,
  output logic               lock_lost,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int unsigned WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned MR_W = $clog2(UNLOCK_MISS + 1);
  localparam state_t      RESET_ST = (WARMUP == 0) ? ST_SEARCH : ST_WARMUP;

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   run_q, run_nx;
  logic [CNT_W-1:0]   max_q, max_nx;
  logic [CNT_W-1:0]   miss_q, miss_nx;
  logic [WU_W-1:0]    wu_q, wu_nx;
  logic [MR_W-1:0]    mr_q, mr_nx;
  logic               lost_q, lost_nx;

  // Saturating increments; a saturated run still counts as a match.
  logic [CNT_W-1:0]   run_inc, miss_inc;
  logic [WU_W-1:0]    wu_inc;
  logic [MR_W-1:0]    mr_inc;

  assign run_inc  = (run_q  == '1) ? run_q  : run_q  + CNT_W'(1);
  assign miss_inc = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
  assign wu_inc   = wu_q + WU_W'(1);
  assign mr_inc   = mr_q + MR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_ST;
      run_q   <= '0;
      max_q   <= '0;
      miss_q  <= '0;
      wu_q    <= '0;
      mr_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      run_q   <= run_nx;
      max_q   <= max_nx;
      miss_q  <= miss_nx;
      wu_q    <= wu_nx;
      mr_q    <= mr_nx;
      lost_q  <= lost_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    run_nx   = run_q;
    max_nx   = max_q;
    miss_nx  = miss_q;
    wu_nx    = wu_q;
    mr_nx    = mr_q;
    lost_nx  = 1'b0;

    if (clear) begin
      // The coincident sample is dropped; warm-up is not repeated.
      state_nx = ST_SEARCH;
      run_nx   = '0;
      max_nx   = '0;
      miss_nx  = '0;
      mr_nx    = '0;
    end else if (eq_bus.eq_valid) begin
      unique case (state_q)
        ST_WARMUP: begin
          wu_nx = wu_inc;
          if (wu_inc == WU_W'(WARMUP))
            state_nx = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (eq_bus.eq_in) begin
            run_nx = run_inc;
            if (run_inc == CNT_W'(LOCK_RUN))
              state_nx = ST_LOCKED;
          end else begin
            run_nx  = '0;
            miss_nx = miss_inc;
          end
        end
        ST_LOCKED: begin
          if (eq_bus.eq_in) begin
            run_nx = run_inc;
            mr_nx  = '0;
          end else begin
            run_nx  = '0;
            miss_nx = miss_inc;
            if (mr_inc == MR_W'(UNLOCK_MISS)) begin
              state_nx = ST_SEARCH;
              lost_nx  = 1'b1;
              mr_nx    = '0;
            end else begin
              mr_nx = mr_inc;
            end
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
      // Peak follows the new run on the same edge, never lagging it.
      if (run_nx > max_q)
        max_nx = run_nx;
    end
  end

  assign run_len   = run_q;
  assign max_run   = max_q;
  assign miss_cnt  = miss_q;
  assign locked    = (state_q == ST_LOCKED);
  assign lock_lost = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_eq_run_monitor.sv
// tb_eq_run_monitor
//   Drives one sample stream into two monitors (default widths, and a
//   3-bit-counter variant for saturation), predicts each output set from a
//   behavioural model, and checks the DUTs through a scoreboard queue.
module tb_eq_run_monitor;

  localparam int WARMUP_P = 2;
  localparam int LOCK_P   = 4;
  localparam int UNLK_P   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;

  eq_run_monitor_if ifc ();

  logic [7:0] run_a, max_a, miss_a;
  logic       lk_a, lost_a;
  logic [1:0] st_a;
  logic [2:0] run_b, max_b, miss_b;
  logic       lk_b, lost_b;
  logic [1:0] st_b;

  eq_run_monitor #(.CNT_W(8), .WARMUP(WARMUP_P), .LOCK_RUN(LOCK_P), .UNLOCK_MISS(UNLK_P)) dut_a (
    .clk(clk), .rst_n(rst_n), .eq_bus(ifc.slave), .clear(clear),
    .run_len(run_a), .max_run(max_a), .miss_cnt(miss_a),
    .locked(lk_a), .lock_lost(lost_a), .state(st_a)
  );

  eq_run_monitor #(.CNT_W(3), .WARMUP(WARMUP_P), .LOCK_RUN(LOCK_P), .UNLOCK_MISS(UNLK_P)) dut_b (
    .clk(clk), .rst_n(rst_n), .eq_bus(ifc.slave), .clear(clear),
    .run_len(run_b), .max_run(max_b), .miss_cnt(miss_b),
    .locked(lk_b), .lock_lost(lost_b), .state(st_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int run;
    int maxr;
    int miss;
    int lk;
    int lost;
    int st;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state, index 0 = dut_a, 1 = dut_b
  int m_run [2];
  int m_max [2];
  int m_miss[2];
  int m_st  [2];
  int m_wu  [2];
  int m_mr  [2];
  int m_lost[2];
  int m_cap [2] = '{255, 7};

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_max[k] = 0; m_miss[k] = 0;
      m_st[k] = (WARMUP_P == 0) ? 1 : 0;
      m_wu[k] = 0; m_mr[k] = 0; m_lost[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input bit e, input bit c);
    m_lost[k] = 0;
    if (c) begin
      m_run[k] = 0; m_max[k] = 0; m_miss[k] = 0; m_st[k] = 1; m_mr[k] = 0;
    end else if (v) begin
      if (m_st[k] == 0) begin
        m_wu[k]++;
        if (m_wu[k] == WARMUP_P) m_st[k] = 1;
      end else if (e) begin
        if (m_run[k] < m_cap[k]) m_run[k]++;
        if (m_st[k] == 2) m_mr[k] = 0;
        else if (m_run[k] == LOCK_P) m_st[k] = 2;
      end else begin
        m_run[k] = 0;
        if (m_miss[k] < m_cap[k]) m_miss[k]++;
        if (m_st[k] == 2) begin
          m_mr[k]++;
          if (m_mr[k] == UNLK_P) begin
            m_st[k] = 1; m_lost[k] = 1; m_mr[k] = 0;
          end
        end
      end
      if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t x;
    x.run = m_run[k]; x.maxr = m_max[k]; x.miss = m_miss[k];
    x.lk = (m_st[k] == 2) ? 1 : 0; x.lost = m_lost[k]; x.st = m_st[k];
    return x;
  endfunction

  task automatic compare_a(input string ctx);
    exp_t x;
    x = qa.pop_front();
    check({ctx, ".a.run"},  int'(run_a),  x.run);
    check({ctx, ".a.max"},  int'(max_a),  x.maxr);
    check({ctx, ".a.miss"}, int'(miss_a), x.miss);
    check({ctx, ".a.lk"},   int'(lk_a),   x.lk);
    check({ctx, ".a.lost"}, int'(lost_a), x.lost);
    check({ctx, ".a.st"},   int'(st_a),   x.st);
  endtask

  task automatic compare_b(input string ctx);
    exp_t x;
    x = qb.pop_front();
    check({ctx, ".b.run"},  int'(run_b),  x.run);
    check({ctx, ".b.max"},  int'(max_b),  x.maxr);
    check({ctx, ".b.miss"}, int'(miss_b), x.miss);
    check({ctx, ".b.lk"},   int'(lk_b),   x.lk);
    check({ctx, ".b.lost"}, int'(lost_b), x.lost);
    check({ctx, ".b.st"},   int'(st_b),   x.st);
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input string ctx, input bit v, input bit e, input bit c);
    @(negedge clk);
    ifc.eq_valid = v;
    ifc.eq_in    = e;
    clear        = c;
    for (int k = 0; k < 2; k++) model_step(k, v, e, c);
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
    @(posedge clk);
    #1;
    compare_a(ctx);
    compare_b(ctx);
  endtask

  // Pull reset between edges and confirm outputs clear before any posedge.
  task automatic async_reset(input string ctx);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
    compare_a(ctx);
    compare_b(ctx);
    ifc.eq_valid = 1'b0;
    clear        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ifc.eq_valid = 1'b0;
    ifc.eq_in    = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
    compare_a("rst");
    compare_b("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Warm-up: two valid mismatches are discarded.
    step("wu0", 1, 0, 0);
    check("wu0.state", int'(st_a), 0);
    step("wu1", 1, 0, 0);
    check("wu1.state", int'(st_a), 1);
    check("wu1.miss", int'(miss_a), 0);

    // Acquire lock.
    for (int i = 0; i < 4; i++) step($sformatf("acq%0d", i), 1, 1, 0);
    check("acq.locked", int'(lk_a), 1);
    check("acq.max", int'(max_a), 4);

    // Lose lock with 0,1,0,0.
    step("lose0", 1, 0, 0);
    step("lose1", 1, 1, 0);
    step("lose2", 1, 0, 0);
    check("lose2.lost", int'(lost_a), 0);
    step("lose3", 1, 0, 0);
    check("lose3.lost", int'(lost_a), 1);
    check("lose3.miss", int'(miss_a), 3);

    // Invalid samples are ignored; the pulse drops after one cycle.
    for (int i = 0; i < 10; i++) step($sformatf("gate%0d", i), 0, i[0], 0);
    check("gate.lost", int'(lost_a), 0);

    // Saturation: 10 matches then 9 misses (dut_b saturates at 7).
    for (int i = 0; i < 10; i++) step($sformatf("sat1_%0d", i), 1, 1, 0);
    check("sat.b.run", int'(run_b), 7);
    check("sat.a.run", int'(run_a), 10);
    for (int i = 0; i < 9; i++) step($sformatf("sat0_%0d", i), 1, 0, 0);
    check("sat.b.miss", int'(miss_b), 7);

    // Clear while locked, with a coincident valid mismatch.
    for (int i = 0; i < 4; i++) step($sformatf("rl%0d", i), 1, 1, 0);
    step("clr", 1, 0, 1);
    check("clr.miss", int'(miss_a), 0);
    check("clr.state", int'(st_a), 1);
    step("clr_hold", 0, 1, 0);

    // Re-lock, then async reset mid-LOCKED; warm-up restarts afterwards.
    for (int i = 0; i < 5; i++) step($sformatf("rl2_%0d", i), 1, 1, 0);
    async_reset("arst");
    step("arst_wu0", 1, 1, 0);
    step("arst_wu1", 1, 1, 0);
    check("arst.run", int'(run_a), 0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++)
      step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 60) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
